vga_scan_compositor: RTL and testbench

Raster timing generator and pixel compositor for the 640x480@60 VGA output. It produces the Q_X/Q_Y scan coordinates that the sprite ROM blocks decode. It takes back their visible/R/G/B response and registers the composited colour together with HSYNC, VSYNC and BLANK_N for the DAC. It sits between the board clock and the sprite ROMs, at the top of the video path.

---
 rtl/vga_scan_compositor.sv | 120 ++++++++++++
 tb/tb_vga_scan_compositor.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/vga_scan_compositor.sv
// Raster timing generator and pixel compositor for a VGA DAC.
// It produces scan coordinates for the sprite ROMs and registers their colour
// response together with the sync and blank signals.
module vga_scan_compositor #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned H_VIS   = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_VIS   = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33,
  parameter logic [7:0]  BG_R    = 8'h00,
  parameter logic [7:0]  BG_G    = 8'h00,
  parameter logic [7:0]  BG_B    = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] Q_X,
  output logic [9:0] Q_Y,
  input  logic       spr_visible,
  input  logic [7:0] spr_R,
  input  logic [7:0] spr_G,
  input  logic [7:0] spr_B,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_CLK,
  output logic       frame_start
);

  localparam int unsigned CW       = 10;
  localparam int unsigned DW       = 2;
  localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_VIS + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VIS + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [DW-1:0] div_cnt;
  logic          pix_en;
  logic          line_end;
  logic          frame_end;
  logic          active;
  logic          hs_n;
  logic          vs_n;

  // Pixel strobe and region decode on the current scan position
  assign pix_en    = (div_cnt == DW'(CLK_DIV - 1));
  assign line_end  = (Q_X == CW'(H_TOTAL - 1));
  assign frame_end = line_end && (Q_Y == CW'(V_TOTAL - 1));
  assign active    = (Q_X < CW'(H_VIS)) && (Q_Y < CW'(V_VIS));
  assign hs_n      = !((Q_X >= CW'(HS_START)) && (Q_X < CW'(HS_END)));
  assign vs_n      = !((Q_Y >= CW'(VS_START)) && (Q_Y < CW'(VS_END)));
  assign VGA_CLK   = pix_en;

  // Clock divider producing one pixel strobe every CLK_DIV clocks
  always_ff @(posedge clk) begin
    if (rst || pix_en) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Horizontal/vertical scan counters and the frame wrap pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      Q_X         <= '0;
      Q_Y         <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && frame_end;
      if (pix_en) begin
        if (line_end) begin
          Q_X <= '0;
          Q_Y <= frame_end ? '0 : Q_Y + CW'(1);
        end else begin
          Q_X <= Q_X + CW'(1);
        end
      end
    end
  end

  // Output stage: syncs, blank and composited colour for the current pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
    end else if (pix_en) begin
      VGA_HS      <= hs_n;
      VGA_VS      <= vs_n;
      VGA_BLANK_N <= active;
      if (!active) begin
        // ROM response is untrusted outside the visible area
        VGA_R <= '0;
        VGA_G <= '0;
        VGA_B <= '0;
      end else if (spr_visible) begin
        VGA_R <= spr_R;
        VGA_G <= spr_G;
        VGA_B <= spr_B;
      end else begin
        VGA_R <= BG_R;
        VGA_G <= BG_G;
        VGA_B <= BG_B;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_compositor.sv
// Bench for vga_scan_compositor on a shrunken raster so several frames fit a
// short run. Expected values come from a pixel-count model: edges since reset
// give the pixel index, which gives the scan position and the captured input.
module tb_vga_scan_compositor;

  localparam int CD  = 2;
  localparam int HV  = 16;
  localparam int HF  = 2;
  localparam int HSY = 3;
  localparam int HB  = 3;
  localparam int VV  = 6;
  localparam int VF  = 2;
  localparam int VSY = 2;
  localparam int VB  = 2;
  localparam int HT  = HV + HF + HSY + HB;
  localparam int VT  = VV + VF + VSY + VB;
  localparam int TOT = HT * VT;
  localparam logic [23:0] BG = 24'h0A0B0C;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] q_x, q_y;
  logic       spr_visible;
  logic [7:0] spr_r, spr_g, spr_b;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n, vga_clk, frame_start;

  always #5 clk = ~clk;

  vga_scan_compositor #(
    .CLK_DIV(CD), .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .BG_R(BG[23:16]), .BG_G(BG[15:8]), .BG_B(BG[7:0])
  ) dut (
    .clk(clk), .rst(rst), .Q_X(q_x), .Q_Y(q_y),
    .spr_visible(spr_visible), .spr_R(spr_r), .spr_G(spr_g), .spr_B(spr_b),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .VGA_HS(vga_hs), .VGA_VS(vga_vs), .VGA_BLANK_N(vga_blank_n),
    .VGA_CLK(vga_clk), .frame_start(frame_start)
  );

  int          checks = 0;
  int          errors = 0;
  int          k = 0;
  int          mode = 0;
  bit          have_pix = 0;
  bit          cap_vis = 0;
  logic [23:0] cap_rgb = '0;
  int          cap_x = 0;
  int          cap_y = 0;
  bit          fs_exp = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every DUT output against the model state
  task automatic check_outputs();
    int pos;
    bit act, hs, vs;
    logic [23:0] rgb;
    pos = (k / CD) % TOT;
    check_eq("q_x", 32'(q_x), 32'(pos % HT));
    check_eq("q_y", 32'(q_y), 32'(pos / HT));
    check_eq("vga_clk", 32'(vga_clk), 32'((k % CD) == CD - 1));
    check_eq("frame_start", 32'(frame_start), 32'(fs_exp));
    if (have_pix) begin
      act = (cap_x < HV) && (cap_y < VV);
      hs  = !((cap_x >= HV + HF) && (cap_x < HV + HF + HSY));
      vs  = !((cap_y >= VV + VF) && (cap_y < VV + VF + VSY));
      rgb = act ? (cap_vis ? cap_rgb : BG) : 24'h0;
    end else begin
      act = 0; hs = 1; vs = 1; rgb = 24'h0;
    end
    check_eq("vga_hs", 32'(vga_hs), 32'(hs));
    check_eq("vga_vs", 32'(vga_vs), 32'(vs));
    check_eq("vga_blank_n", 32'(vga_blank_n), 32'(act));
    check_eq("vga_rgb", 32'({vga_r, vga_g, vga_b}), 32'(rgb));
  endtask

  // Drive one clock of stimulus, advance the model, then check
  task automatic step(input bit r);
    int pos, x, y;
    bit pe;
    logic v;
    logic [23:0] c;
    pe  = (k % CD) == CD - 1;
    pos = (k / CD) % TOT;
    x   = pos % HT;
    y   = pos / HT;
    case (mode)
      0: begin v = 1'($urandom_range(0, 1)); c = 24'($urandom); end
      1: begin
        v = (x >= 4) && (x < 9) && (y >= 1) && (y < 4);
        c = v ? 24'hFFFFFF : 24'($urandom);
      end
      default: begin v = 1'b1; c = 24'h123456; end
    endcase
    if (!pe && mode != 2) begin
      spr_visible = 1'($urandom_range(0, 1));
      {spr_r, spr_g, spr_b} = 24'($urandom);
    end else begin
      spr_visible = v;
      {spr_r, spr_g, spr_b} = c;
    end
    rst = r;
    @(posedge clk);
    if (r) begin
      k = 0; have_pix = 0; fs_exp = 0;
    end else begin
      if (pe) begin
        have_pix = 1; cap_vis = v; cap_rgb = c; cap_x = x; cap_y = y;
      end
      k++;
      fs_exp = pe && (((k / CD) % TOT) == 0);
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    int pos;
    bit found;
    rst = 1'b1;
    spr_visible = 1'b0;
    {spr_r, spr_g, spr_b} = 24'h0;
    @(negedge clk);
    repeat (3) step(1);

    // Random sprite data over two full frames
    mode = 0;
    repeat (2 * TOT * CD) step(0);
    repeat (3) begin
      repeat ($urandom_range(50, 300)) step(0);
      step(1);
    end

    // Rectangular white sprite
    mode = 1;
    repeat (2 * TOT * CD + 10) step(0);

    // Single-clock reset in the middle of a visible line
    found = 0;
    for (int i = 0; i < TOT * CD + 4 && !found; i++) begin
      pos = (k / CD) % TOT;
      if (pos == 3 * HT + 10) found = 1;
      else step(0);
    end
    check_eq("reset_target_reached", 32'(found), 32'(1));
    step(1);
    repeat (4 * CD) step(0);

    // Constant always-visible sprite colour
    mode = 2;
    repeat (TOT * CD + 10) step(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
